// File: rtl/uart_ascii_pkg.sv
`default_nettype none
// ============================================================================
// Package  : uart_ascii_pkg
// Brief    : ASCII constants and the parse-state encoding shared by UART text
//            senders and receivers.
// Revision : 1.0
// ============================================================================
package uart_ascii_pkg;

    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_9  = 8'h39;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCUM   = 2'd1,
        ST_DISCARD = 2'd2
    } rx_state_e;

endpackage
`default_nettype wire

// File: rtl/ascii_digit_decode.sv
`default_nettype none
// ============================================================================
// Module   : ascii_digit_decode
// Brief    : Combinational classifier: byte -> decimal digit / line terminator.
// Revision : 1.0
// ============================================================================
module ascii_digit_decode
    import uart_ascii_pkg::*;
(
    input  logic [7:0] i_byte,
    output logic       o_is_digit,
    output logic       o_is_term,
    output logic [3:0] o_digit
);

    assign o_is_digit = (i_byte >= ASCII_0) && (i_byte <= ASCII_9);
    assign o_is_term  = (i_byte == ASCII_CR) || (i_byte == ASCII_LF);
    // Low nibble equals the digit value for 0x30..0x39; meaningless otherwise.
    assign o_digit    = i_byte[3:0];

endmodule
`default_nettype wire

// File: rtl/receiver_uart.sv
`default_nettype none
// ============================================================================
// Module   : receiver_uart
// Brief    : Pops ASCII bytes from a FWFT RX FIFO and parses CR/LF terminated
//            decimal lines into a binary value.
// Options  : UART_RX_TIMEOUT_EN - abort a partial line after TIMEOUT_CYCLES idle
// Revision : 1.0
// ============================================================================
module receiver_uart
    import uart_ascii_pkg::*;
#(
    parameter int DATA_W         = 14,
    parameter int MAX_DIGITS     = 4,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              empty,
    input  logic [7:0]        rx_data,
    output logic              pop,
    output logic [DATA_W-1:0] o_value,
    output logic              o_valid,
    output logic              o_error
);

    localparam int CNT_W = $clog2(MAX_DIGITS + 1);

    rx_state_e         state_q, state_d;
    logic [7:0]        byte_q, byte_d;
    logic              byte_vld_q, byte_vld_d;
    logic              pop_q, pop_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] value_q, value_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              valid_q, valid_d;
    logic              error_q, error_d;

    logic              is_digit;
    logic              is_term;
    logic [3:0]        digit;
    logic              tmo_hit;

    ascii_digit_decode u_decode (
        .i_byte     (byte_q),
        .o_is_digit (is_digit),
        .o_is_term  (is_term),
        .o_digit    (digit)
    );

    // Latch the head byte and pop it in the same edge; pop_q blocks a second
    // latch while the FIFO is still presenting the byte being removed.
    always_comb begin
        pop_d      = 1'b0;
        byte_vld_d = 1'b0;
        byte_d     = byte_q;
        if (!empty && !pop_q) begin
            pop_d      = 1'b1;
            byte_vld_d = 1'b1;
            byte_d     = rx_data;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        value_d = value_q;
        valid_d = 1'b0;
        error_d = 1'b0;
        if (byte_vld_q) begin
            case (state_q)
                ST_IDLE: begin
                    if (is_digit) begin
                        acc_d   = DATA_W'(digit);
                        cnt_d   = CNT_W'(1);
                        state_d = ST_ACCUM;
                    end else if (!is_term) begin
                        state_d = ST_DISCARD;
                    end
                end
                ST_ACCUM: begin
                    if (is_digit) begin
                        if (cnt_q == CNT_W'(MAX_DIGITS)) begin
                            state_d = ST_DISCARD;
                        end else begin
                            acc_d = (acc_q << 3) + (acc_q << 1) + DATA_W'(digit);
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else if (is_term) begin
                        value_d = acc_q;
                        valid_d = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DISCARD;
                    end
                end
                ST_DISCARD: begin
                    if (is_term) begin
                        error_d = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (tmo_hit) begin
            error_d = 1'b1;
            state_d = ST_IDLE;
        end
    end

`ifdef UART_RX_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_q, tmo_d;

    // Counts idle cycles of a partial line; any processed byte restarts it.
    always_comb begin
        tmo_d   = tmo_q;
        tmo_hit = 1'b0;
        if (byte_vld_q || (state_q == ST_IDLE)) begin
            tmo_d = '0;
        end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            tmo_d   = '0;
            tmo_hit = 1'b1;
        end else begin
            tmo_d = tmo_q + TMO_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    assign tmo_hit = 1'b0;

    // TIMEOUT_CYCLES has no effect in this build; a partial line waits forever.
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_unused
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            byte_q     <= '0;
            byte_vld_q <= 1'b0;
            pop_q      <= 1'b0;
            acc_q      <= '0;
            cnt_q      <= '0;
            value_q    <= '0;
            valid_q    <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_q     <= byte_d;
            byte_vld_q <= byte_vld_d;
            pop_q      <= pop_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            value_q    <= value_d;
            valid_q    <= valid_d;
            error_q    <= error_d;
        end
    end

    assign pop     = pop_q;
    assign o_value = value_q;
    assign o_valid = valid_q;
    assign o_error = error_q;

endmodule
`default_nettype wire
